// File: rtl/jtag_dma_pkg.sv
// Shared definitions for the JTAG chain-1 DMA engine: defaults, bus widths, FSM states.
package jtag_dma_pkg;

    localparam int unsigned DEF_BUF_ADDR_W = 9;
    localparam int unsigned DEF_MAX_BURST  = 16;

    localparam int unsigned BUS_DATA_W  = 32;
    localparam int unsigned BUS_BE_W    = 4;
    localparam int unsigned BUS_BURST_W = 8;
    localparam int unsigned WORD_CNT_W  = BUS_BURST_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_NEXT
    } dma_state_t;

endpackage

// File: rtl/dma_burst_splitter.sv
// Computes beats-minus-one for the next bus transaction so that it never
// crosses a MAX_BURST-word aligned block nor exceeds the words remaining.
module dma_burst_splitter
    import jtag_dma_pkg::*;
#(
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [BUS_DATA_W-1:0]  address,
    input  logic [WORD_CNT_W-1:0]  remaining,
    output logic [BUS_BURST_W-1:0] beat_cnt
);

    logic [31:0] word_offset;
    logic [31:0] block_room;
    logic [31:0] beats;

    always_comb begin
        word_offset = (address >> 2) & (MAX_BURST - 1);
        block_room  = MAX_BURST - word_offset;
        beats       = block_room;
        if (32'(remaining) < beats) begin
            beats = 32'(remaining);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if (load) begin
            beat_cnt <= BUS_BURST_W'(beats - 1);
        end
    end

endmodule

// File: rtl/jtag_dma_engine.sv
// Bus-master DMA between the chain-1 ping-pong buffer system port and the
// shared bus: writes stream buffer words out, reads fill the buffer.
module jtag_dma_engine
    import jtag_dma_pkg::*;
#(
    parameter int unsigned BUF_ADDR_W = DEF_BUF_ADDR_W,
    parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            dma_address,
    input  logic [3:0]             dma_byte_enable,
    input  logic [7:0]             dma_burst_size,
    input  logic                   dma_data_ready,
    input  logic                   dma_readReady,
    output logic                   switch_ready,
    output logic                   dma_done,
    output logic                   dma_error,
    output logic [BUF_ADDR_W-1:0]  buf_address,
    output logic                   buf_writeEnable,
    output logic [31:0]            buf_dataIn,
    input  logic [31:0]            buf_dataOut,
    output logic                   requestTransaction,
    input  logic                   transactionGranted,
    output logic                   beginTransactionOut,
    output logic [31:0]            addressDataOut,
    output logic [3:0]             byteEnablesOut,
    output logic [7:0]             burstSizeOut,
    output logic                   readNotWriteOut,
    output logic                   dataValidOut,
    output logic                   endTransactionOut,
    input  logic [31:0]            addressDataIn,
    input  logic                   dataValidIn,
    input  logic                   busyIn,
    input  logic                   endTransactionIn,
    input  logic                   errorIn
);

    dma_state_t             state_q, state_d;
    logic [31:0]            addr_q;
    logic [3:0]             be_q;
    logic [WORD_CNT_W-1:0]  remaining_q;
    logic                   rnw_q;
    logic [BUF_ADDR_W-1:0]  ptr_q;
    logic [WORD_CNT_W-1:0]  wbeat_q;
    logic [31:0]            skid_q;
    logic                   skid_vld_q;
    logic                   err_q;
    logic                   err_pulse_q;

    logic [BUS_BURST_W-1:0] beat_cnt;
    logic [WORD_CNT_W-1:0]  beats;
    logic                   last_op;
    logic                   bus_err;
    logic                   w_active;
    logic                   accept;
    logic [31:0]            wr_data;

    dma_burst_splitter #(
        .MAX_BURST(MAX_BURST)
    ) u_splitter (
        .clock    (clock),
        .reset    (reset),
        .load     (state_q == ST_REQ),
        .address  (addr_q),
        .remaining(remaining_q),
        .beat_cnt (beat_cnt)
    );

    assign beats     = {1'b0, beat_cnt} + 9'd1;
    assign last_op   = (remaining_q == beats);
    assign bus_err   = errorIn && (state_q inside {ST_ADDR, ST_WDATA, ST_RDATA});
    assign w_active  = (state_q == ST_WDATA) && (wbeat_q != beats);
    assign accept    = (state_q == ST_IDLE) && (dma_data_ready || dma_readReady);
    assign wr_data   = skid_vld_q ? skid_q : buf_dataOut;
    assign dma_error = err_q;

    always_comb begin
        state_d             = state_q;
        switch_ready        = 1'b0;
        dma_done            = err_pulse_q;
        buf_address         = ptr_q;
        buf_writeEnable     = 1'b0;
        buf_dataIn          = '0;
        requestTransaction  = 1'b0;
        beginTransactionOut = 1'b0;
        addressDataOut      = '0;
        byteEnablesOut      = '0;
        burstSizeOut        = '0;
        readNotWriteOut     = 1'b0;
        dataValidOut        = 1'b0;
        endTransactionOut   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                switch_ready = 1'b1;
                if (accept) state_d = ST_REQ;
            end
            ST_REQ: begin
                requestTransaction = 1'b1;
                if (transactionGranted) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                beginTransactionOut = 1'b1;
                addressDataOut      = addr_q;
                burstSizeOut        = beat_cnt;
                readNotWriteOut     = rnw_q;
                byteEnablesOut      = rnw_q ? 4'hF : be_q;
                state_d             = rnw_q ? ST_RDATA : ST_WDATA;
            end
            ST_WDATA: begin
                // Always prefetch the word after the current beat; the skid holds the current one.
                buf_address = ptr_q + BUF_ADDR_W'(1);
                if (w_active) begin
                    dataValidOut   = 1'b1;
                    addressDataOut = wr_data;
                    byteEnablesOut = be_q;
                end else begin
                    endTransactionOut = 1'b1;
                    state_d           = ST_NEXT;
                end
            end
            ST_RDATA: begin
                buf_writeEnable = dataValidIn;
                buf_dataIn      = addressDataIn;
                if (endTransactionIn) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                dma_done = err_pulse_q || last_op;
                state_d  = last_op ? ST_IDLE : ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus_err) begin
            endTransactionOut = 1'b0;
            state_d           = ST_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            be_q        <= '0;
            remaining_q <= '0;
            rnw_q       <= 1'b0;
            ptr_q       <= '0;
            wbeat_q     <= '0;
            skid_q      <= '0;
            skid_vld_q  <= 1'b0;
            err_q       <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_pulse_q <= bus_err;
            if (bus_err) err_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q      <= dma_address & 32'hFFFF_FFFC;
                        be_q        <= dma_byte_enable;
                        remaining_q <= {1'b0, dma_burst_size} + 9'd1;
                        rnw_q       <= !dma_data_ready;
                        ptr_q       <= '0;
                        err_q       <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    wbeat_q    <= '0;
                    skid_vld_q <= 1'b0;
                end
                ST_WDATA: begin
                    if (w_active) begin
                        if (busyIn) begin
                            if (!skid_vld_q) begin
                                skid_q     <= buf_dataOut;
                                skid_vld_q <= 1'b1;
                            end
                        end else begin
                            skid_vld_q <= 1'b0;
                            ptr_q      <= ptr_q + BUF_ADDR_W'(1);
                            wbeat_q    <= wbeat_q + 9'd1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (dataValidIn) ptr_q <= ptr_q + BUF_ADDR_W'(1);
                end
                ST_NEXT: begin
                    addr_q      <= addr_q + {21'b0, beats, 2'b00};
                    remaining_q <= remaining_q - beats;
                    if (last_op) ptr_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_dma_engine.sv
// Scoreboard bench for jtag_dma_engine: directed transfers against a bus slave
// and ping-pong buffer model, checked by a decoupled negedge monitor.
module tb_jtag_dma_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] dma_address;
    logic [3:0]  dma_byte_enable;
    logic [7:0]  dma_burst_size;
    logic        dma_data_ready, dma_readReady;
    logic        switch_ready, dma_done, dma_error;
    logic [8:0]  buf_address;
    logic        buf_writeEnable;
    logic [31:0] buf_dataIn, buf_dataOut;
    logic        requestTransaction, transactionGranted, beginTransactionOut;
    logic [31:0] addressDataOut, addressDataIn;
    logic [3:0]  byteEnablesOut;
    logic [7:0]  burstSizeOut;
    logic        readNotWriteOut, dataValidOut, endTransactionOut;
    logic        dataValidIn, busyIn, endTransactionIn, errorIn;

    jtag_dma_engine #(
        .BUF_ADDR_W(9),
        .MAX_BURST (16)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .dma_address        (dma_address),
        .dma_byte_enable    (dma_byte_enable),
        .dma_burst_size     (dma_burst_size),
        .dma_data_ready     (dma_data_ready),
        .dma_readReady      (dma_readReady),
        .switch_ready       (switch_ready),
        .dma_done           (dma_done),
        .dma_error          (dma_error),
        .buf_address        (buf_address),
        .buf_writeEnable    (buf_writeEnable),
        .buf_dataIn         (buf_dataIn),
        .buf_dataOut        (buf_dataOut),
        .requestTransaction (requestTransaction),
        .transactionGranted (transactionGranted),
        .beginTransactionOut(beginTransactionOut),
        .addressDataOut     (addressDataOut),
        .byteEnablesOut     (byteEnablesOut),
        .burstSizeOut       (burstSizeOut),
        .readNotWriteOut    (readNotWriteOut),
        .dataValidOut       (dataValidOut),
        .endTransactionOut  (endTransactionOut),
        .addressDataIn      (addressDataIn),
        .dataValidIn        (dataValidIn),
        .busyIn             (busyIn),
        .endTransactionIn   (endTransactionIn),
        .errorIn            (errorIn)
    );

    always #5 clock = ~clock;

    // Buffer model: synchronous read, one-cycle latency, loaded with A500_0000+i.
    logic [31:0] mem [512];
    bit          mem_loaded;
    always @(posedge clock) begin
        if (reset && !mem_loaded) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'hA500_0000 + 32'(i);
            mem_loaded <= 1'b1;
        end else if (buf_writeEnable) begin
            mem[buf_address] <= buf_dataIn;
        end
        buf_dataOut <= mem[buf_address];
    end

    // Scoreboard queues: address phase {addr,bs,rnw,be}, write beats, buffer writes {addr,data}, done {err,end_prev}.
    logic [44:0] exp_addr [$];
    logic [31:0] exp_wd   [$];
    logic [40:0] exp_bw   [$];
    logic [1:0]  exp_done [$];
    int n_cmp = 0, n_fail = 0, n_done = 0;

    int          grant_delay = 0;
    logic [31:0] busy_mask = '0, gap_mask = '0;
    int          err_beat = -1;
    int          rd_cnt = 0;

    initial begin : bus_slave
        int wait_n, beat, nb, cyc;
        bit in_xfer, rd_xfer;
        logic dv, et, bt, rq, rnw_s;
        logic [7:0] bs_s;
        wait_n = 0; beat = 0; nb = 0; cyc = 0; in_xfer = 0; rd_xfer = 0;
        transactionGranted = 0; busyIn = 0; dataValidIn = 0; endTransactionIn = 0;
        errorIn = 0; addressDataIn = '0;
        forever begin
            @(posedge clock); #1;
            dv = dataValidOut; et = endTransactionOut; bt = beginTransactionOut;
            rq = requestTransaction; rnw_s = readNotWriteOut; bs_s = burstSizeOut;
            transactionGranted = 0; busyIn = 0; dataValidIn = 0; endTransactionIn = 0;
            errorIn = 0; addressDataIn = '0;
            if (reset) begin
                in_xfer = 0;
                wait_n  = 0;
            end else begin
                if (in_xfer) begin
                    busyIn = busy_mask[cyc % 32];
                    if (!rd_xfer) begin
                        if (dv && beat == err_beat) begin
                            errorIn = 1;
                            in_xfer = 0;
                        end else begin
                            if (dv && !busyIn) beat++;
                            if (et) in_xfer = 0;
                        end
                    end else if (!gap_mask[cyc % 32]) begin
                        dataValidIn   = 1;
                        addressDataIn = 32'hC0DE_0000 + 32'(rd_cnt);
                        rd_cnt++;
                        beat++;
                        if (beat == nb) begin
                            endTransactionIn = 1;
                            in_xfer = 0;
                        end
                    end
                    cyc++;
                end
                if (bt) begin
                    in_xfer = 1; rd_xfer = rnw_s; nb = int'(bs_s) + 1; beat = 0; cyc = 0;
                end
                if (rq) begin
                    if (wait_n >= grant_delay) begin
                        transactionGranted = 1;
                        wait_n = 0;
                    end else begin
                        wait_n++;
                    end
                end
            end
        end
    end

    logic end_prev = 1'b0;
    always @(negedge clock) begin : monitor
        logic [44:0] ea;
        logic [40:0] eb;
        logic [1:0]  ed;
        if (reset) begin
            end_prev = 1'b0;
        end else begin
            if (beginTransactionOut) begin
                n_cmp++;
                if (exp_addr.size() == 0) begin
                    n_fail++;
                    $display("FAIL addr_phase: unexpected transaction addr=%h bs=%0d rnw=%0d", addressDataOut, burstSizeOut, readNotWriteOut);
                end else begin
                    ea = exp_addr.pop_front();
                    if ({addressDataOut, burstSizeOut, readNotWriteOut, byteEnablesOut} !== ea) begin
                        n_fail++;
                        $display("FAIL addr_phase: got addr=%h bs=%0d rnw=%0d be=%h, want addr=%h bs=%0d rnw=%0d be=%h",
                                 addressDataOut, burstSizeOut, readNotWriteOut, byteEnablesOut,
                                 ea[44:13], ea[12:5], ea[4], ea[3:0]);
                    end
                end
            end
            if (dataValidOut && !errorIn) begin
                n_cmp++;
                if (exp_wd.size() == 0) begin
                    n_fail++;
                    $display("FAIL write_beat: unexpected beat data=%h", addressDataOut);
                end else begin
                    if (addressDataOut !== exp_wd[0] || byteEnablesOut === 4'h0) begin
                        n_fail++;
                        $display("FAIL write_beat: got data=%h be=%h busy=%0d, want data=%h", addressDataOut, byteEnablesOut, busyIn, exp_wd[0]);
                    end
                    if (!busyIn) void'(exp_wd.pop_front());
                end
            end
            if (buf_writeEnable) begin
                n_cmp++;
                if (exp_bw.size() == 0) begin
                    n_fail++;
                    $display("FAIL buf_write: unexpected write addr=%0d data=%h", buf_address, buf_dataIn);
                end else begin
                    eb = exp_bw.pop_front();
                    if ({buf_address, buf_dataIn} !== eb) begin
                        n_fail++;
                        $display("FAIL buf_write: got addr=%0d data=%h, want addr=%0d data=%h", buf_address, buf_dataIn, eb[40:32], eb[31:0]);
                    end
                end
            end
            if (dma_done) begin
                n_cmp++;
                n_done++;
                if (exp_done.size() == 0) begin
                    n_fail++;
                    $display("FAIL dma_done: unexpected done pulse");
                end else begin
                    ed = exp_done.pop_front();
                    if ({dma_error, end_prev} !== ed) begin
                        n_fail++;
                        $display("FAIL dma_done: got error=%0d end_prev_cycle=%0d, want error=%0d end_prev_cycle=%0d", dma_error, end_prev, ed[1], ed[0]);
                    end
                end
            end
            end_prev = endTransactionOut;
        end
    end

    localparam logic [93:0] RESET_VEC = {1'b1, 93'd0};

    function automatic logic [93:0] out_vec();
        return {switch_ready, dma_done, dma_error, buf_address, buf_writeEnable, buf_dataIn,
                requestTransaction, beginTransactionOut, addressDataOut, byteEnablesOut,
                burstSizeOut, readNotWriteOut, dataValidOut, endTransactionOut};
    endfunction

    task automatic check_bit(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_reset_vec(input string name);
        n_cmp++;
        if (out_vec() !== RESET_VEC) begin
            n_fail++;
            $display("FAIL %s: outputs got %h want %h", name, out_vec(), RESET_VEC);
        end
    endtask

    task automatic issue(input bit wr, input bit rd, input logic [31:0] a,
                         input logic [7:0] bs, input logic [3:0] be);
        @(posedge clock); #1;
        dma_address = a; dma_burst_size = bs; dma_byte_enable = be;
        dma_data_ready = wr; dma_readReady = rd;
        @(posedge clock); #1;
        dma_data_ready = 0; dma_readReady = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int start_n, k;
        start_n = n_done;
        k = 0;
        while (n_done == start_n && k < budget) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (n_done == start_n) begin
            n_fail++;
            $display("FAIL %s: no dma_done within %0d cycles (got 0 want 1)", name, budget);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic check_empty(input string name, input int sz);
        n_cmp++;
        if (sz != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected items left, want 0", name, sz);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset = 1; dma_address = '0; dma_byte_enable = '0; dma_burst_size = '0;
        dma_data_ready = 0; dma_readReady = 0;
        #2;
        check_reset_vec("reset_state");
        @(negedge clock); @(negedge clock);
        reset = 0;

        // 4 words at 0x1000, grant after 2 cycles
        grant_delay = 2; busy_mask = '0; gap_mask = '0; err_beat = -1;
        exp_addr.push_back({32'h0000_1000, 8'd3, 1'b0, 4'hF});
        for (int i = 0; i < 4; i++) exp_wd.push_back(32'hA500_0000 + 32'(i));
        exp_done.push_back(2'b01);
        issue(1, 0, 32'h0000_1000, 8'd3, 4'hF);
        wait_done("write4", 200);

        // 20 words at 0xFF0 split 4 + 16 at the 64-byte boundary
        grant_delay = 0;
        exp_addr.push_back({32'h0000_0FF0, 8'd3, 1'b0, 4'h3});
        exp_addr.push_back({32'h0000_1000, 8'd15, 1'b0, 4'h3});
        for (int i = 0; i < 20; i++) exp_wd.push_back(32'hA500_0000 + 32'(i));
        exp_done.push_back(2'b01);
        issue(1, 0, 32'h0000_0FF2, 8'd19, 4'h3);
        wait_done("write20_split", 400);

        // busy held 5 cycles on the third beat
        busy_mask = 32'h0000_007C;
        exp_addr.push_back({32'h0000_2000, 8'd7, 1'b0, 4'hF});
        for (int i = 0; i < 8; i++) exp_wd.push_back(32'hA500_0000 + 32'(i));
        exp_done.push_back(2'b01);
        issue(1, 0, 32'h0000_2000, 8'd7, 4'hF);
        wait_done("write_busy", 300);

        // write and read pulses together: only the write happens
        busy_mask = '0;
        exp_addr.push_back({32'h0000_7000, 8'd1, 1'b0, 4'hC});
        exp_wd.push_back(32'hA500_0000);
        exp_wd.push_back(32'hA500_0001);
        exp_done.push_back(2'b01);
        issue(1, 1, 32'h0000_7000, 8'd1, 4'hC);
        wait_done("both_pulses", 200);
        repeat (10) @(negedge clock);

        // bus error on the second write beat
        err_beat = 1;
        exp_addr.push_back({32'h0000_3000, 8'd3, 1'b0, 4'hF});
        exp_wd.push_back(32'hA500_0000);
        exp_done.push_back(2'b10);
        issue(1, 0, 32'h0000_3000, 8'd3, 4'hF);
        wait_done("write_error", 200);
        check_bit("error_sticky", dma_error, 1'b1);
        check_bit("error_idle", switch_ready, 1'b1);

        // single-word read clears the sticky error
        err_beat = -1;
        exp_addr.push_back({32'h0000_6000, 8'd0, 1'b1, 4'hF});
        exp_bw.push_back({9'd0, 32'hC0DE_0000});
        exp_done.push_back(2'b00);
        issue(0, 1, 32'h0000_6000, 8'd0, 4'h5);
        check_bit("error_cleared", dma_error, 1'b0);
        check_bit("busy_not_switch", switch_ready, 1'b0);
        wait_done("read1", 200);

        // 3-word read with busy toggling and valid gaps
        grant_delay = 1; busy_mask = 32'hAAAA_AAAA; gap_mask = 32'h0000_000D;
        exp_addr.push_back({32'h0000_5000, 8'd2, 1'b1, 4'hF});
        exp_bw.push_back({9'd0, 32'hC0DE_0001});
        exp_bw.push_back({9'd1, 32'hC0DE_0002});
        exp_bw.push_back({9'd2, 32'hC0DE_0003});
        exp_done.push_back(2'b00);
        issue(0, 1, 32'h0000_5000, 8'd2, 4'h1);
        wait_done("read3_gaps", 300);
        check_bit("switch_ready_after_read", switch_ready, 1'b1);

        check_empty("addr_queue", exp_addr.size());
        check_empty("wdata_queue", exp_wd.size());
        check_empty("bufw_queue", exp_bw.size());
        check_empty("done_queue", exp_done.size());

        // reset in the middle of a 16-word write; first words come from earlier reads
        grant_delay = 0; busy_mask = '0; gap_mask = '0;
        exp_addr.push_back({32'h0000_8000, 8'd15, 1'b0, 4'hF});
        exp_wd.push_back(32'hC0DE_0001);
        exp_wd.push_back(32'hC0DE_0002);
        exp_wd.push_back(32'hC0DE_0003);
        for (int i = 3; i < 16; i++) exp_wd.push_back(32'hA500_0000 + 32'(i));
        issue(1, 0, 32'h0000_8000, 8'd15, 4'hF);
        for (int k = 0; k < 200 && exp_wd.size() > 13; k++) @(negedge clock);
        n_cmp++;
        if (exp_wd.size() > 13) begin
            n_fail++;
            $display("FAIL midburst_wait: %0d beats left, want at most 13", exp_wd.size());
        end
        #2;
        reset = 1;
        #1;
        check_reset_vec("reset_midburst");
        exp_addr.delete(); exp_wd.delete(); exp_bw.delete(); exp_done.delete();
        @(negedge clock); @(negedge clock);
        reset = 0;
        repeat (4) @(negedge clock);
        check_reset_vec("idle_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_dma_engine.md
Name: jtag_dma_engine

Overview:
- Bus-master DMA that serves the DMA-request side of the JTAG chain-1 ping-pong buffer, on the system clock.
- Write request: streams the words chain 1 filled into the buffer out onto the shared bus as bursts.
- Read request: fetches words from the bus into the buffer for chain 1 to shift out.
- Sits between the ping-pong buffer's system-side port and the shared bus arbiter. Request pulses arrive already synchronized to clock by the upstream synchronizer.

Parameters:
- BUF_ADDR_W, 9, ping-pong buffer address width (word addressed).
- MAX_BURST, 16, maximum beats per bus transaction; power of two, at most 256.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dma_address  in  32  start byte address; word aligned, bits [1:0] ignored
- dma_byte_enable  in  4  byte enables applied to every write beat
- dma_burst_size  in  8  total words minus one (0 means 1 word, 255 means 256 words)
- dma_data_ready  in  1  one-cycle pulse: buffer filled, start a bus write
- dma_readReady  in  1  one-cycle pulse: start a bus read into the buffer
- switch_ready  out  1  high when idle; chain 1 may switch buffers
- dma_done  out  1  one-cycle pulse when an operation completes
- dma_error  out  1  sticky; cleared by the next accepted request
- buf_address  out  BUF_ADDR_W  buffer address
- buf_writeEnable  out  1  buffer write strobe
- buf_dataIn  out  32  data written to the buffer
- buf_dataOut  in  32  buffer read data; one-cycle latency
- requestTransaction  out  1  bus request
- transactionGranted  in  1  arbiter grant
- beginTransactionOut  out  1  address-phase strobe
- addressDataOut  out  32  address in address phase, data in write beats
- byteEnablesOut  out  4  byte enables
- burstSizeOut  out  8  beats minus one for this transaction
- readNotWriteOut  out  1  1 = read transaction
- dataValidOut  out  1  write beat valid
- endTransactionOut  out  1  end of master transaction
- addressDataIn  in  32  read data
- dataValidIn  in  1  read beat valid
- busyIn  in  1  slave stall
- endTransactionIn  in  1  slave ends transaction
- errorIn  in  1  bus error

Behaviour:
- Reset: all outputs 0 except switch_ready=1; state IDLE; all counters 0.
- IDLE:
  - dma_data_ready latches address, byte enables, remaining = dma_burst_size+1, rnw=0, clears dma_error, goes to REQ.
  - dma_readReady does the same with rnw=1.
  - Both pulses in the same cycle: write wins; the read pulse is dropped.
  - Requests outside IDLE are ignored.
  - switch_ready=1 only in IDLE.
- REQ: requestTransaction=1 until transactionGranted, then ADDR.
  - beat_cnt = min(remaining, MAX_BURST, words left to the next MAX_BURST*4-byte boundary) - 1.
  - For writes, buf_address = buffer pointer is presented here (prefetch).
- ADDR (1 cycle): beginTransactionOut=1, addressDataOut=current address, burstSizeOut=beat_cnt, readNotWriteOut=rnw, byteEnablesOut=rnw ? 4'hF : latched enables. Then WDATA or RDATA.
- WDATA:
  - dataValidOut=1 with addressDataOut=buf_dataOut.
  - The beat advances only when busyIn=0. On advance, increment the buffer pointer and present the next buffer address, so data is ready the next cycle. While busy, hold the data stable via a skid register.
  - After the last beat, one cycle with endTransactionOut=1, then NEXT.
- RDATA:
  - Each cycle with dataValidIn=1: buf_writeEnable=1, buf_dataIn=addressDataIn, buf_address=pointer, then pointer++.
  - endTransactionIn moves to NEXT. Beats received before it are kept even if fewer than expected.
- NEXT:
  - Byte address += 4*beats, remaining -= beats.
  - remaining==0: dma_done pulse, buffer pointer reset to 0, return to IDLE.
  - Otherwise go to REQ.
  - Buffer pointer wraps at 2^BUF_ADDR_W.
- errorIn in ADDR/WDATA/RDATA: drop request, set dma_error, dma_done pulse, go to IDLE. No endTransactionOut is driven on error.
- Asynchronous reset mid-transaction forces all bus outputs low immediately.
- Address arithmetic is 32-bit and wraps. Burst splitting guarantees a transaction never crosses a MAX_BURST-word aligned block.

Decomposition:
- Shared package jtag_dma_pkg:
  - state encoding (IDLE, REQ, ADDR, WDATA, RDATA, NEXT)
  - MAX_BURST and BUF_ADDR_W defaults
  - bus field widths
- One sub-module, dma_burst_splitter: combinational plus registered computation of the next beat count from address and remaining.

Test Plan:
- Write of 4 words (burst 3) at 0x00001000, BE=4'hF, grant after 2 cycles, no busy -> one transaction, burstSizeOut=3, data = buffer words 0..3 on 4 consecutive beats, dma_done 1 cycle after endTransactionOut.
- Write of 20 words at 0x00000FF0 with MAX_BURST=16 -> bursts of 4 words at 0xFF0 and 16 words at 0x1000; buffer pointer continues 4..19 across the bursts.
- Read of 3 words with busyIn toggling and dataValidIn gaps -> buffer addresses 0,1,2 written with the bus data in order; switch_ready returns to 1 after dma_done.
- WDATA with busyIn held 5 cycles mid-burst -> addressDataOut stable throughout, no beat lost or duplicated.
- errorIn during the second write beat -> dma_error=1, dma_done pulse, IDLE. The next dma_readReady clears dma_error.
- dma_data_ready and dma_readReady in the same cycle -> write performed, read ignored. Reset asserted mid-burst -> all outputs at reset values in the same cycle.
